// File: rtl/lcd_cmd_dispatch.sv
// Host command FIFO feeding the LCD image controller one command at a time,
// paced on lcd_busy; after the write command (4'h0) it waits for lcd_done.
module lcd_cmd_dispatch #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          i_clk,
    input  logic          i_reset,      // active low, asynchronous
    input  logic [3:0]    i_host_cmd,
    input  logic          i_host_push,
    output logic          o_host_full,
    input  logic          i_lcd_busy,
    input  logic          i_lcd_done,
    output logic [3:0]    o_cmd,
    output logic          o_cmd_valid,
    output logic [AW:0]   o_fifo_cnt,
    output logic [7:0]    o_issued_cnt,
    output logic          o_err_ovf,
    output logic          o_err_cmd,
    output logic          o_finished
);
    localparam logic [AW:0] LP_DEPTH   = (AW+1)'(DEPTH);
    localparam logic [3:0]  LP_MAX_CMD = 4'hB;
    localparam logic [3:0]  LP_WR_CMD  = 4'h0;

    typedef enum logic [2:0] {S_IDLE, S_ACK, S_WAIT, S_DRAIN, S_DONE} state_t;

    state_t        r_state, w_state_nxt;
    logic [3:0]    r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr, r_wr_ptr;
    logic [AW:0]   r_cnt;
    logic [3:0]    r_cmd, w_cmd_nxt;
    logic          r_cmd_valid, w_valid_nxt;
    logic          r_finished, w_fin_nxt;
    logic [7:0]    r_issued;
    logic          r_err_ovf, r_err_cmd;

    logic          w_full, w_legal, w_wr_en, w_rd_en;
    logic [3:0]    w_head;

    assign w_full  = (r_cnt == LP_DEPTH);
    assign w_legal = (i_host_cmd <= LP_MAX_CMD);
    // full is judged on the pre-pop count: a pop in the same cycle does not make room
    assign w_wr_en = i_host_push && w_legal && !w_full;
    assign w_head  = r_mem[r_rd_ptr];

    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        w_cmd_nxt   = r_cmd;
        w_valid_nxt = 1'b0;
        w_fin_nxt   = r_finished;
        case (r_state)
            S_IDLE: begin
                if (r_cnt != '0 && !i_lcd_busy) begin
                    w_rd_en     = 1'b1;
                    w_cmd_nxt   = w_head;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = (w_head == LP_WR_CMD) ? S_DRAIN : S_ACK;
                end
            end
            // controller raises busy during this cycle, so busy is not looked at
            S_ACK:   w_state_nxt = S_WAIT;
            S_WAIT:  if (!i_lcd_busy) w_state_nxt = S_IDLE;
            S_DRAIN: begin
                if (i_lcd_done) begin
                    w_state_nxt = S_DONE;
                    w_fin_nxt   = 1'b1;
                end
            end
            S_DONE:  w_fin_nxt = 1'b1;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= S_IDLE;
            r_cmd       <= '0;
            r_cmd_valid <= 1'b0;
            r_finished  <= 1'b0;
            r_issued    <= '0;
            r_err_ovf   <= 1'b0;
            r_err_cmd   <= 1'b0;
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd       <= w_cmd_nxt;
            r_cmd_valid <= w_valid_nxt;
            r_finished  <= w_fin_nxt;
            if (i_host_push && w_full)   r_err_ovf <= 1'b1;
            if (i_host_push && !w_legal) r_err_cmd <= 1'b1;
            if (w_rd_en && r_issued != 8'hFF) r_issued <= r_issued + 8'd1;
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr_en, w_rd_en})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // storage needs no reset: entries are only read after being written
    always_ff @(posedge i_clk) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= i_host_cmd;
    end

    assign o_host_full  = w_full;
    assign o_cmd        = r_cmd;
    assign o_cmd_valid  = r_cmd_valid;
    assign o_fifo_cnt   = r_cnt;
    assign o_issued_cnt = r_issued;
    assign o_err_ovf    = r_err_ovf;
    assign o_err_cmd    = r_err_cmd;
    assign o_finished   = r_finished;

endmodule

// File: tb/tb_lcd_cmd_dispatch.sv
// Randomized and directed bench for lcd_cmd_dispatch, checked every cycle
// against a queue-based behavioural model plus literal expectations.
module tb_lcd_cmd_dispatch;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  host_cmd = '0;
    logic        host_push = 1'b0;
    logic        lcd_busy = 1'b0;
    logic        lcd_done = 1'b0;
    logic        host_full;
    logic [3:0]  cmd;
    logic        cmd_valid;
    logic [AW:0] fifo_cnt;
    logic [7:0]  issued_cnt;
    logic        err_ovf, err_cmd, finished;

    lcd_cmd_dispatch #(.DEPTH(DEPTH), .AW(AW)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_host_cmd(host_cmd), .i_host_push(host_push),
        .o_host_full(host_full), .i_lcd_busy(lcd_busy), .i_lcd_done(lcd_done),
        .o_cmd(cmd), .o_cmd_valid(cmd_valid), .o_fifo_cnt(fifo_cnt),
        .o_issued_cnt(issued_cnt), .o_err_ovf(err_ovf), .o_err_cmd(err_cmd),
        .o_finished(finished)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: a queue of pending codes plus the issue pacing rules.
    // holdoff: 0 = may issue, 1 = cycle right after an issue, 2 = waiting for busy low.
    logic [3:0] mq[$];
    int  m_cmd = 0, m_valid = 0, m_issued = 0, m_ovf = 0, m_ecmd = 0, m_fin = 0;
    bit  m_written = 0;
    int  m_holdoff = 0;
    bit  m_iss, m_full, m_was_wr;
    logic [3:0] m_c;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_cmd = 0; m_valid = 0; m_issued = 0; m_ovf = 0; m_ecmd = 0; m_fin = 0;
            m_written = 0; m_holdoff = 0;
        end else begin
            m_was_wr = m_written;
            m_full   = (mq.size() == DEPTH);
            m_iss    = !m_written && m_holdoff == 0 && mq.size() != 0 && !lcd_busy;
            if (host_push && host_cmd > 4'hB) m_ecmd = 1;
            if (host_push && m_full) m_ovf = 1;
            m_valid = 0;
            if (m_holdoff == 1) m_holdoff = 2;
            else if (m_holdoff == 2 && !lcd_busy) m_holdoff = 0;
            if (m_iss) begin
                m_c = mq.pop_front();
                m_cmd = m_c; m_valid = 1;
                if (m_issued != 255) m_issued++;
                if (m_c == 4'h0) m_written = 1; else m_holdoff = 1;
            end
            if (host_push && host_cmd <= 4'hB && !m_full) mq.push_back(host_cmd);
            if (m_was_wr && lcd_done) m_fin = 1;
        end
    end

    logic [3:0] seen[$];

    always @(negedge clk) begin
        chk("cmd", cmd, m_cmd);
        chk("cmd_valid", cmd_valid, m_valid);
        chk("fifo_cnt", fifo_cnt, mq.size());
        chk("issued_cnt", issued_cnt, m_issued);
        chk("err_ovf", err_ovf, m_ovf);
        chk("err_cmd", err_cmd, m_ecmd);
        chk("finished", finished, m_fin);
        chk("host_full", host_full, (mq.size() == DEPTH) ? 1 : 0);
        if (cmd_valid) seen.push_back(cmd);
    end

    // one clock of stimulus; returns 1 time unit after the consuming edge
    task automatic cyc(input bit p, input logic [3:0] c, input bit b, input bit d);
        host_push = p; host_cmd = c; lcd_busy = b; lcd_done = d;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        rst_n = 1'b1;
    endtask

    task automatic chk_seen(input string name, input int n, input logic [31:0] packed_exp);
        logic [31:0] pe;
        pe = packed_exp;
        chk({name, "_len"}, seen.size(), n);
        for (int i = 0; i < n && i < seen.size(); i++)
            chk(name, seen[i], int'(pe[4*i +: 4]));
    endtask

    initial begin
        // reset state
        cyc(0, 0, 0, 0);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_fifo_cnt", fifo_cnt, 0);
        chk("rst_issued", issued_cnt, 0);
        chk("rst_finished", finished, 0);
        rst_n = 1'b1;
        cyc(0, 0, 0, 0);

        // latency: push in N, strobe in N+2 only
        seen.delete();
        cyc(1, 4'h4, 0, 0);
        chk("t2_n1_valid", cmd_valid, 0);
        cyc(0, 0, 0, 0);
        chk("t2_n2_valid", cmd_valid, 1);
        chk("t2_n2_cmd", cmd, 4);
        cyc(0, 0, 0, 0);
        chk("t2_n3_valid", cmd_valid, 0);
        chk("t2_fifo_cnt", fifo_cnt, 0);
        chk("t2_issued", issued_cnt, 1);
        chk("t2_cmd_hold", cmd, 4);
        repeat (3) cyc(0, 0, 0, 0);

        // overflow while busy, then FIFO-order drain with busy pulses
        seen.delete();
        for (int i = 1; i <= 9; i++) begin
            cyc(1, 4'(i), 1, 0);
            if (i == 8) chk("t3_full_after8", host_full, 1);
        end
        chk("t3_err_ovf", err_ovf, 1);
        chk("t3_fifo_cnt", fifo_cnt, 8);
        chk("t3_no_issue_busy", seen.size(), 0);
        for (int i = 0; i < 100; i++) cyc(0, 0, (i % 3) != 0, 0);
        chk_seen("t3_order", 8, 32'h8765_4321);
        chk("t3_issued", issued_cnt, 9);

        // reset mid-burst
        for (int i = 0; i < 3; i++) cyc(1, 4'(i + 2), 1, 0);
        chk("t1_queued", fifo_cnt, 3);
        rst_n = 1'b0;
        #1;
        chk("t1_fifo_cnt", fifo_cnt, 0);
        chk("t1_issued", issued_cnt, 0);
        chk("t1_err_ovf", err_ovf, 0);
        chk("t1_cmd", cmd, 0);
        cyc(0, 0, 0, 0);
        rst_n = 1'b1;
        seen.delete();
        repeat (6) cyc(0, 0, 0, 0);
        chk("t1_no_issue", seen.size(), 0);

        // illegal code dropped
        do_reset();
        seen.delete();
        cyc(1, 4'hC, 0, 0);
        cyc(1, 4'h5, 0, 0);
        repeat (6) cyc(0, 0, 0, 0);
        chk("t4_err_cmd", err_cmd, 1);
        chk_seen("t4_seen", 1, 32'h5);
        chk("t4_issued", issued_cnt, 1);

        // write command stops issue; lcd_done finishes
        do_reset();
        seen.delete();
        cyc(1, 4'h9, 1, 0);
        cyc(1, 4'h0, 1, 0);
        cyc(1, 4'h1, 1, 0);
        for (int i = 0; i < 30; i++) cyc(0, 0, (i % 3) != 0, 0);
        chk_seen("t5_seen", 2, 32'h09);
        chk("t5_fifo_cnt", fifo_cnt, 1);
        chk("t5_not_fin", finished, 0);
        cyc(0, 0, 0, 1);
        chk("t5_finished", finished, 1);
        cyc(0, 0, 0, 0);
        chk("t5_fin_sticky", finished, 1);

        // simultaneous push and pop at count 1
        do_reset();
        seen.delete();
        cyc(1, 4'hA, 0, 0);
        cyc(1, 4'hB, 0, 0);
        chk("t6_cnt", fifo_cnt, 1);
        chk("t6_valid", cmd_valid, 1);
        chk("t6_cmd", cmd, 4'hA);
        repeat (6) cyc(0, 0, 0, 0);
        chk_seen("t6_order", 2, 32'hBA);

        // randomized episodes; last one avoids writes to reach saturation
        for (int ep = 0; ep < 6; ep++) begin
            int ncyc;
            ncyc = (ep == 5) ? 1500 : 400;
            do_reset();
            for (int i = 0; i < ncyc; i++) begin
                logic [3:0] c;
                int r;
                r = $urandom_range(0, 99);
                if (r < 4 && ep != 5) c = 4'h0;
                else if (r < 9) c = 4'($urandom_range(12, 15));
                else c = 4'($urandom_range(1, 11));
                if (ep != 5 && $urandom_range(0, 149) == 0) rst_n = 1'b0;
                cyc($urandom_range(0, 1) == 1, c,
                    (ep == 5) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) == 0),
                    $urandom_range(0, 19) == 0);
                rst_n = 1'b1;
            end
            if (ep == 5) chk("sat_issued", issued_cnt, 255);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
